// File: rtl/switch_debounce.sv
// Switch debouncer: a 2-flop synchronizer followed by an independent hold counter per bit.
// Define SWITCH_DEBOUNCE_EDGE_EN to add registered per-bit rise/fall pulse outputs.
module switch_debounce #(
  parameter int unsigned      WIDTH           = 18,
  parameter int unsigned      DEBOUNCE_CYCLES = 1000000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_raw,
  output logic [WIDTH-1:0] out_stable,
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  output logic             change,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`else
  output logic             change
`endif
);

  localparam int unsigned      CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] upd;

  // in_raw is asynchronous to clk; nothing touches it before the second flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      sync1  <= in_raw;
      sync_q <= sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt;
      logic             differs;

      assign differs = (sync_q[gi] != out_stable[gi]);

      // Counter clears on agreement or on acceptance, so it stops at CNT_MAX and never wraps
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt <= '0;
        end else if (!differs) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign upd[gi] = differs && (cnt == CNT_MAX);
    end
  endgenerate

  // All bits accepted on the same edge land in out_stable together
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_stable <= RESET_VALUE;
      change     <= 1'b0;
    end else begin
      out_stable <= (out_stable & ~upd) | (sync_q & upd);
      change     <= |upd;
    end
  end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= upd & sync_q;
      fall <= upd & ~sync_q;
    end
  end
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Randomized and directed bench for switch_debounce (WIDTH=18, DEBOUNCE_CYCLES=4).
// Reference model: a bit is accepted once its last D synchronized samples all differ from out_stable.
module tb_switch_debounce;

  localparam int W = 18;
  localparam int D = 4;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] in_raw;
  logic [W-1:0] out_stable;
  logic         change;
  logic [W-1:0] rise;
  logic [W-1:0] fall;

  int n_checks;
  int n_fail;

  // reference model state
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] sq_hist[$];
  logic [W-1:0] m_stable;
  logic         m_change;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;

  switch_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .RESET_VALUE    ('0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_raw    (in_raw),
    .out_stable(out_stable),
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    .change    (change),
    .rise      (rise),
    .fall      (fall)
`else
    .change    (change)
`endif
  );

`ifndef SWITCH_DEBOUNCE_EDGE_EN
  assign rise = '0;
  assign fall = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    raw_hist.delete();
    sq_hist.delete();
    m_stable = '0;
    m_change = 1'b0;
    m_rise   = '0;
    m_fall   = '0;
  endtask

  // Advance one clock, update the model from in_raw, then wait past the edge for sampling
  task automatic tick();
    logic [W-1:0] sqp;
    logic [W-1:0] upd;
    logic [W-1:0] s;
    bit           all_diff;
    @(posedge clk);
    if (!reset_n) begin
      model_clear();
    end else begin
      sqp = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : '0;
      raw_hist.push_back(in_raw);
      sq_hist.push_back(sqp);
      upd = '0;
      if (sq_hist.size() >= D) begin
        for (int i = 0; i < W; i++) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++) begin
            s = sq_hist[sq_hist.size()-1-j];
            if (s[i] == m_stable[i]) all_diff = 1'b0;
          end
          upd[i] = all_diff;
        end
      end
      m_change = |upd;
      m_rise   = upd & sqp;
      m_fall   = upd & ~sqp;
      m_stable = m_stable ^ upd;
      while (raw_hist.size() > 8) void'(raw_hist.pop_front());
      while (sq_hist.size() > 8) void'(sq_hist.pop_front());
    end
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_raw  = '0;
    #1;
    model_clear();
    n_checks++;
    if (out_stable !== '0 || change !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: out_stable=%h change=%b, expected 0/0", out_stable, change);
    end
    settle(2);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if (out_stable !== '0 || change !== 1'b0 || rise !== '0 || fall !== '0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: out=%h chg=%b rise=%h fall=%h, expected all 0",
                 k, out_stable, change, rise, fall);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_single_rise();
    logic [W-1:0] e_out;
    in_raw = 18'h00001;
    for (int k = 0; k < 9; k++) begin
      tick();
      e_out = (k >= 5) ? 18'h00001 : 18'h00000;
      n_checks++;
      if (out_stable !== e_out || change !== (k == 5)) begin
        n_fail++;
        $display("FAIL single_rise[%0d]: out=%h chg=%b, expected out=%h chg=%b",
                 k, out_stable, change, e_out, (k == 5));
      end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
      n_checks++;
      if (rise !== ((k == 5) ? 18'h00001 : 18'h00000) || fall !== '0) begin
        n_fail++;
        $display("FAIL single_rise_edge[%0d]: rise=%h fall=%h", k, rise, fall);
      end
`endif
    end
    $display("test_single_rise done");
  endtask

  task automatic test_glitch();
    in_raw = '0;
    settle(8);
    in_raw = 18'h00020;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) in_raw = '0;
      tick();
      n_checks++;
      if (out_stable !== '0 || change !== 1'b0 || rise !== '0 || fall !== '0) begin
        n_fail++;
        $display("FAIL glitch[%0d]: out=%h chg=%b rise=%h fall=%h, expected all 0",
                 k, out_stable, change, rise, fall);
      end
    end
    $display("test_glitch done");
  endtask

  task automatic test_toggle();
    int n_pulses;
    int pulse_at;
    n_pulses = 0;
    pulse_at = -1;
    for (int k = 0; k < 25; k++) begin
      in_raw = (k >= 10 || ((k / 2) % 2 == 0)) ? 18'h20000 : 18'h00000;
      tick();
      if (change === 1'b1) begin
        n_pulses++;
        pulse_at = k;
      end
      n_checks++;
      if (out_stable !== m_stable || change !== m_change) begin
        n_fail++;
        $display("FAIL toggle_model[%0d]: out=%h chg=%b, expected out=%h chg=%b",
                 k, out_stable, change, m_stable, m_change);
      end
    end
    n_checks++;
    if (n_pulses != 1 || pulse_at != 13 || out_stable !== 18'h20000) begin
      n_fail++;
      $display("FAIL toggle_summary: pulses=%0d at=%0d out=%h, expected 1 at 13 out=20000",
               n_pulses, pulse_at, out_stable);
    end
    $display("test_toggle done");
  endtask

  task automatic test_same_cycle();
    logic [W-1:0] e_out;
    in_raw = '0;
    settle(8);
    in_raw = 18'h00003;
    for (int k = 0; k < 9; k++) begin
      tick();
      e_out = (k >= 5) ? 18'h00003 : 18'h00000;
      n_checks++;
      if (out_stable !== e_out || change !== (k == 5)) begin
        n_fail++;
        $display("FAIL same_cycle[%0d]: out=%h chg=%b, expected out=%h chg=%b",
                 k, out_stable, change, e_out, (k == 5));
      end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
      n_checks++;
      if (rise !== ((k == 5) ? 18'h00003 : 18'h00000) || fall !== '0) begin
        n_fail++;
        $display("FAIL same_cycle_edge[%0d]: rise=%h fall=%h, expected rise=%h fall=0",
                 k, rise, fall, ((k == 5) ? 18'h00003 : 18'h00000));
      end
`endif
    end
    $display("test_same_cycle done");
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e_out;
    in_raw = 18'h00004;
    settle(4);
    reset_n = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if (out_stable !== '0 || change !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: out=%h chg=%b, expected 0/0", out_stable, change);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (out_stable !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_hold[%0d]: out=%h, expected 0", k, out_stable);
      end
    end
    reset_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      e_out = (k >= 5) ? 18'h00004 : 18'h00000;
      n_checks++;
      if (out_stable !== e_out || change !== (k == 5)) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: out=%h chg=%b, expected out=%h chg=%b",
                 k, out_stable, change, e_out, (k == 5));
      end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
      n_checks++;
      if (rise !== ((k == 5) ? 18'h00004 : 18'h00000)) begin
        n_fail++;
        $display("FAIL reset_mid_rise[%0d]: rise=%h", k, rise);
      end
`endif
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int hold;
    int cyc;
    cyc = 0;
    while (cyc < 800) begin
      in_raw = in_raw ^ (18'h00001 << $urandom_range(0, W - 1));
      if ($urandom_range(0, 3) == 0) in_raw = in_raw ^ ($urandom() & 18'h3FFFF);
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        tick();
        cyc++;
        n_checks++;
        if (out_stable !== m_stable || change !== m_change) begin
          n_fail++;
          $display("FAIL random[%0d]: out=%h chg=%b, expected out=%h chg=%b",
                   cyc, out_stable, change, m_stable, m_change);
        end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        n_checks++;
        if (rise !== m_rise || fall !== m_fall) begin
          n_fail++;
          $display("FAIL random_edge[%0d]: rise=%h fall=%h, expected rise=%h fall=%h",
                   cyc, rise, fall, m_rise, m_fall);
        end
`endif
      end
    end
    $display("test_random done, %0d cycles", cyc);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    in_raw   = '0;
    test_reset();
    test_single_rise();
    test_glitch();
    test_toggle();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: WIDTH, 18, number of switch inputs debounced.
REQ-003 Parameter: DEBOUNCE_CYCLES, 1000000, consecutive clocks a changed input must hold before acceptance (20 ms at 50 MHz); legal range 2..2^24.
REQ-004 Parameter: RESET_VALUE, all zeros (WIDTH bits), value loaded into all state on reset.
REQ-005 Port: clk  input  1  system clock; all flops on rising edge.
REQ-006 Port: reset_n  input  1  asynchronous active-low reset.
REQ-007 Port: in_raw  input  WIDTH  raw, asynchronous, bouncing switch pins.
REQ-008 Port: out_stable  output  WIDTH  debounced vector; drives the switch PIO in_port.
REQ-009 Port: change  output  1  one-cycle pulse when any out_stable bit updates.
REQ-010 Port (EDGE_EN builds only): rise  output  WIDTH  one-cycle per-bit pulse on out_stable 0->1.
REQ-011 Port (EDGE_EN builds only): fall  output  WIDTH  one-cycle per-bit pulse on out_stable 1->0.

Function
REQ-012 Each in_raw bit SHALL pass through a 2-flop synchronizer (sync1, then sync_q) before any other use.
REQ-013 Each bit SHALL own an independent counter cnt[i], width ceil(log2(DEBOUNCE_CYCLES)).
REQ-014 Per clock, per bit: if sync_q[i]==out_stable[i], cnt[i]<=0.
REQ-015 Per clock, per bit: else if cnt[i]==DEBOUNCE_CYCLES-1, out_stable[i]<=sync_q[i] and cnt[i]<=0.
REQ-016 Per clock, per bit: otherwise cnt[i]<=cnt[i]+1; the counter SHALL never wrap.
REQ-017 Latency: a clean in_raw[i] change captured at edge 0 SHALL appear on out_stable[i] after edge DEBOUNCE_CYCLES+1 (DEBOUNCE_CYCLES+2 edges total).
REQ-018 Any sync_q[i] excursion shorter than DEBOUNCE_CYCLES clocks SHALL leave out_stable[i] unchanged; a return to the stable value restarts the count from 0.
REQ-019 change SHALL be registered, asserting for exactly the one clock following an edge on which at least one out_stable bit updated; multiple bits updating on the same edge produce a single pulse.
REQ-020 Bits updating on the same edge SHALL appear on out_stable together; no bit-to-bit skew beyond that of in_raw itself.
REQ-021 out_stable SHALL be driven directly from flops (glitch-free into the PIO register).

Reset
REQ-022 While reset_n=0, asynchronously: sync1, sync_q and out_stable = RESET_VALUE; all cnt = 0; change = 0; rise = fall = 0 (if present).
REQ-023 Reset asserted mid-count SHALL discard partial counts; after release, a differing input SHALL again require the full DEBOUNCE_CYCLES.
REQ-024 The first edges after reset release SHALL produce no change, rise or fall pulse unless a bit completes a full debounce count.

Configuration
REQ-025 Macro SWITCH_DEBOUNCE_EDGE_EN defined: rise and fall ports exist and are registered per bit, aligned with change (same cycle).
REQ-026 Macro SWITCH_DEBOUNCE_EDGE_EN undefined: rise and fall ports and their logic are absent; all other behaviour is identical.

Verification (DEBOUNCE_CYCLES=4, WIDTH=18, RESET_VALUE=0, EDGE_EN defined)
REQ-027 Reset, hold in_raw=0x00000 for 20 clocks -> out_stable=0x00000, change=0, rise=fall=0 throughout.
REQ-028 in_raw[0] 0->1 held -> out_stable=0x00001 after 6th edge; change=1 and rise[0]=1 for exactly one clock, aligned.
REQ-029 in_raw[5] high for 3 clocks then low -> out_stable stays 0x00000, no change/rise/fall pulse.
REQ-030 in_raw[17] toggled every 2 clocks for 10 clocks, then held 1 -> single update to 0x20000, 6 edges after final transition, one change pulse.
REQ-031 in_raw 0x00000->0x00003 in same cycle -> bits 0 and 1 update on the same edge, one change pulse, rise=0x00003.
REQ-032 in_raw[2] set, reset_n pulsed low after 2 counted clocks, in_raw held -> out_stable=0 during reset; bit 2 updates only 6 edges after release.
